mux_rr_n: RTL and testbench
===========================

Name: mux_rr_n

Overview:
- Parametrised successor to the 2:1 mux: N-input, W-bit multiplexer with valid/ready handshakes and a registered output stage.
- An internal arbiter (round-robin or fixed-priority) picks the source.
- Used wherever several producers share one downstream consumer, such as bus merging or time-division channel muxing.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel.
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SW, $clog2(N), select/index width (derived, localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  N*W  packed channel data; channel k occupies bits [k*W +: W].
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel accept, one-hot or zero.
- out_data  out  W  registered selected data.
- out_sel  out  SW  index of the channel held in out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset: all of the following take effect on the rising edge while rst=1.
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst=1.
  - Reset mid-transfer discards the held word, with no handshake completed.
- Load enable: load = ~out_valid | out_ready.
- Grant (combinational):
  - RR=1: the first k with in_valid[k]=1, scanning ptr, ptr+1, … wrapping mod N.
  - RR=0: the lowest k with in_valid[k]=1.
  - No valid input means no grant.
- in_ready[k] = load & grant[k] & ~rst. At most one bit is high. in_ready never depends on in_valid of a non-granted channel.
- Transfer: input transfer on channel k when in_valid[k] & in_ready[k]. Output transfer when out_valid & out_ready.
- Clock edge with load=1:
  - With a grant: out_data <= in_data[k], out_sel <= k, out_valid <= 1. In RR mode, ptr <= (k+1) mod N, wrapping from N-1 to 0.
  - No grant: out_valid <= 0. out_data and out_sel hold their last values.
- Clock edge with load=0: register and ptr hold. Sources must hold valid/data, the standard valid/ready rule.
- Latency and throughput: 1 cycle from input transfer to out_valid. Full throughput of 1 word/cycle when out_ready=1 continuously, including a simultaneous output drain and new load.
- ptr advances only on a completed input transfer, never on idle cycles or stalls.
- Fairness (RR=1): with all N channels continuously valid, the grant sequence is 0,1,…,N-1,0,…. No channel waits more than N-1 grants.
- N not a power of 2: the wrap uses an explicit compare to N-1, not a natural overflow.

Optional Feature:
- Macro: MUX_RR_LOCK_EN.
- When defined:
  - Extra input in_last [N] is added.
  - The grant locks to the current channel until a transfer with in_last[k]=1. Packet mode: other channels are ignored while locked, even if the locked channel drops valid.
  - ptr advances only on the last beat.
  - Reset clears the lock.
- When undefined: no in_last port; arbitration is re-evaluated every transfer, as described above.

Decomposition:
- Shared package mux_pkg: localparam helper for the select width (clog2 with minimum 1) and the RR/FIXED mode constants.
- Natural sub-module rr_arbiter_n. Interface: req[N], ptr[SW], mode → grant[N], grant_idx[SW]. It is purely combinational and reusable by other muxes.
- The top level holds the output register, ptr and lock state.

Test Plan:
All scenarios use N=4, W=8.
- Reset: assert rst with all in_valid=1 → in_ready=0000, out_valid=0, out_data=00, out_sel=0 on the first edge.
- RR fairness: in_valid=1111, data k = 8'hA0+k, out_ready=1 → out_sel sequence 0,1,2,3,0 with out_data A0,A1,A2,A3,A0, one per cycle.
- Fixed mode, RR=0: in_valid=1010 held → out_sel stays 1 every cycle and channel 3 is never granted.
- Backpressure: out_ready=0 for 3 cycles with a word held (55 from channel 2) → out_data stays 55, in_ready=0000, ptr unchanged. Releasing out_ready drains 55 and loads the next grant (channel 3) on the same edge.
- Wrap and skip: ptr=3, in_valid=0101 → grant channel 0, ptr becomes 1. Next grant is channel 2.
- MUX_RR_LOCK_EN: channel 1 sends 3 beats with in_last on beat 3 while channel 2 is valid → channel 2 is granted only after beat 3.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-input valid/ready multiplexers.
// Select width is clog2(N) clamped to at least one bit.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational N-way arbiter: round-robin starting at ptr, or fixed priority
// (lowest index wins). Emits a one-hot grant plus its index.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic          found;
  logic [SW:0]   cand;
  logic [SW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int i = 0; i < N; i++) begin
      cand = (SW+1)'(i);
      if (mode == MODE_RR) begin
        // Explicit wrap so non-power-of-two N never lands on an unused index.
        cand = {1'b0, ptr} + (SW+1)'(i);
        if (cand > (SW+1)'(N - 1)) begin
          cand = cand - (SW+1)'(N);
        end
      end
      cand_idx = cand[SW-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-input W-bit valid/ready multiplexer with arbitrated source and registered
// output. Define MUX_RR_LOCK_EN to add in_last and packet-locked arbitration.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RR = 1,
  localparam int SW = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
`ifdef MUX_RR_LOCK_EN
  input  logic [N-1:0]   in_last,
`endif
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [W-1:0]  chan_data [N];
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          any_grant;
  logic          load;
  logic          beat_last;

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*W +: W];
    end
  endgenerate

`ifdef MUX_RR_LOCK_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lock_idx_q, lock_idx_d;
  logic [N-1:0]  lock_mask;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lock
      assign lock_mask[gi] = (lock_idx_q == SW'(gi));
    end
  endgenerate

  // While locked, only the owning channel may be granted, valid or not.
  assign req       = lock_q ? (in_valid & lock_mask) : in_valid;
  assign beat_last = in_last[grant_idx];
`else
  assign req       = in_valid;
  assign beat_last = 1'b1;
`endif

  rr_arbiter_n #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .mode      ((RR != 0) ? MODE_RR : MODE_FIXED),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load      = ~out_valid_q | out_ready;
  assign any_grant = |grant;
  assign in_ready  = (load & ~rst) ? grant : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
`ifdef MUX_RR_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (load) begin
      if (any_grant) begin
        out_data_d  = chan_data[grant_idx];
        out_sel_d   = grant_idx;
        out_valid_d = 1'b1;
        if ((RR != 0) && beat_last) begin
          ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
        end
`ifdef MUX_RR_LOCK_EN
        lock_d     = ~beat_last;
        lock_idx_d = grant_idx;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
`ifdef MUX_RR_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
`ifdef MUX_RR_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Self-checking bench for mux_rr_n: round-robin and fixed-priority instances
// against a queue-free behavioural model, plus directed scenario checks.
module tb_mux_rr_n;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic          out_ready;

  logic [N-1:0]  rr_ready, fx_ready;
  logic [W-1:0]  rr_data, fx_data;
  logic [1:0]    rr_sel, fx_sel;
  logic          rr_valid, fx_valid;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = fixed-priority DUT, 1 = round-robin DUT.
  int m_valid [2];
  int m_data  [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_lock  [2];
  int m_lockch[2];
  bit m_init = 0;

  always #5 clk = ~clk;

  mux_rr_n #(.N(N), .W(W), .RR(1)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef MUX_RR_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (rr_ready),
    .out_data  (rr_data),
    .out_sel   (rr_sel),
    .out_valid (rr_valid),
    .out_ready (out_ready)
  );

  mux_rr_n #(.N(N), .W(W), .RR(0)) u_fx (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef MUX_RR_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (fx_ready),
    .out_data  (fx_data),
    .out_sel   (fx_sel),
    .out_valid (fx_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel chosen by the model for instance m, or -1 if nobody is eligible.
  function automatic int pick(input int m);
    int k;
`ifdef MUX_RR_LOCK_EN
    if (m_lock[m] != 0) return in_valid[m_lockch[m]] ? m_lockch[m] : -1;
`endif
    for (int off = 0; off < N; off++) begin
      k = (m == 1) ? (m_ptr[m] + off) % N : off;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  // One clock: check comb/registered outputs, advance model, land on next negedge.
  task automatic tick();
    int g;
    bit ld, lst;
    logic [N-1:0] exp_rdy;
    int nv[2], nd[2], ns[2], np[2], nl[2], nlc[2];
    #1;
    for (int m = 0; m < 2; m++) begin
      g  = pick(m);
      ld = (m_valid[m] == 0) || out_ready;
      exp_rdy = (!rst && ld && g >= 0) ? N'(1 << g) : '0;
      if (m == 1) check("rr_in_ready", 32'(rr_ready), 32'(exp_rdy));
      else        check("fx_in_ready", 32'(fx_ready), 32'(exp_rdy));
      if (m_init) begin
        if (m == 1) begin
          check("rr_out_valid", 32'(rr_valid), 32'(m_valid[m]));
          check("rr_out_data", 32'(rr_data), 32'(m_data[m]));
          check("rr_out_sel", 32'(rr_sel), 32'(m_sel[m]));
        end else begin
          check("fx_out_valid", 32'(fx_valid), 32'(m_valid[m]));
          check("fx_out_data", 32'(fx_data), 32'(m_data[m]));
          check("fx_out_sel", 32'(fx_sel), 32'(m_sel[m]));
        end
      end
      nv[m] = m_valid[m]; nd[m] = m_data[m]; ns[m] = m_sel[m];
      np[m] = m_ptr[m];   nl[m] = m_lock[m]; nlc[m] = m_lockch[m];
      if (rst) begin
        nv[m] = 0; nd[m] = 0; ns[m] = 0; np[m] = 0; nl[m] = 0; nlc[m] = 0;
      end else if (ld) begin
        if (g >= 0) begin
`ifdef MUX_RR_LOCK_EN
          lst = in_last[g];
`else
          lst = 1'b1;
`endif
          nv[m] = 1; nd[m] = int'(in_data[g*W +: W]); ns[m] = g;
          if (m == 1 && lst) np[m] = (g + 1) % N;
          nl[m] = lst ? 0 : 1; nlc[m] = g;
        end else begin
          nv[m] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = nv[m]; m_data[m] = nd[m]; m_sel[m] = ns[m];
      m_ptr[m] = np[m];   m_lock[m] = nl[m]; m_lockch[m] = nlc[m];
    end
    if (rst) m_init = 1;
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic r);
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    in_last   = '1;
    out_ready = 1'b1;
    in_data   = '0;
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_data[m] = 0; m_sel[m] = 0;
      m_ptr[m] = 0;   m_lock[m] = 0; m_lockch[m] = 0;
    end
    @(negedge clk);
    tick();
    // Reset with every channel requesting.
    tick();
    check("reset_in_ready", 32'(rr_ready), 32'h0);
    check("reset_out_valid", 32'(rr_valid), 32'h0);
    check("reset_out_data", 32'(rr_data), 32'h0);
    check("reset_out_sel", 32'(rr_sel), 32'h0);
    rst = 1'b0;

    // Round-robin fairness: A0..A3, continuous drain.
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'hA0 + 8'(k);
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_fair_sel", 32'(rr_sel), 32'(i % N));
      check("rr_fair_data", 32'(rr_data), 32'(8'hA0 + 8'(i % N)));
    end

    // Fixed priority: channel 3 starved by channel 1.
    drive(4'b1010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fx_sel_stays_1", 32'(fx_sel), 32'd1);
      check("fx_ch3_never", 32'(fx_ready[3]), 32'd0);
    end

    // Backpressure with 55 held from channel 2, then release.
    do_reset();
    in_data[2*W +: W] = 8'h55;
    in_data[3*W +: W] = 8'h77;
    drive(4'b0100, 1'b1);
    tick();
    drive(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data_held", 32'(rr_data), 32'h55);
      check("bp_in_ready", 32'(rr_ready), 32'h0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_sel", 32'(rr_sel), 32'd3);
    check("bp_release_data", 32'(rr_data), 32'h77);

    // Wrap and skip from ptr=3.
    do_reset();
    drive(4'b0100, 1'b1);
    tick();
    drive(4'b0101, 1'b1);
    tick();
    check("wrap_sel0", 32'(rr_sel), 32'd0);
    tick();
    check("skip_sel2", 32'(rr_sel), 32'd2);

`ifdef MUX_RR_LOCK_EN
    // Channel 1 sends a 3-beat packet while channel 2 waits.
    do_reset();
    drive(4'b0110, 1'b1);
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2) ? 4'b0110 : 4'b0000;
      tick();
      check("lock_beat_sel1", 32'(rr_sel), 32'd1);
    end
    in_last = 4'b1111;
    tick();
    check("lock_then_ch2", 32'(rr_sel), 32'd2);
`endif

    // Randomised traffic, including mid-transfer resets.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
